// File: rtl/beep_scheduler.sv
// beep_scheduler: queues wall/block hit requests and plays each as a
// square-wave beep followed by a silent gap, feeding the audio DAC FIFO.
// Ports: CLOCK_50 (clock), reset (sync, active high),
//   wall_obstacle / block_obstacle (level requests),
//   audio_out_allowed (FIFO has space) -> write_audio_out (strobe),
//   sample_out (signed sample), beep_active, tone_sel (01 wall, 10 block).
module beep_scheduler #(
  parameter int unsigned BEEP_CYCLES = 10000000,
  parameter int unsigned GAP_CYCLES  = 2500000,
  parameter int unsigned WALL_HALF   = 24,
  parameter int unsigned BLOCK_HALF  = 48,
  parameter logic [31:0] AMP         = 32'h01000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        wall_obstacle,
  input  logic        block_obstacle,
  input  logic        audio_out_allowed,
  output logic        write_audio_out,
  output logic [31:0] sample_out,
  output logic        beep_active,
  output logic [1:0]  tone_sel
);

  typedef enum logic [1:0] {
    IDLE,
    BEEP,
    GAP
  } state_e;

  localparam logic [1:0] TONE_NONE  = 2'b00;
  localparam logic [1:0] TONE_WALL  = 2'b01;
  localparam logic [1:0] TONE_BLOCK = 2'b10;

  localparam logic [31:0] BEEP_LAST  = 32'(BEEP_CYCLES - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [15:0] WALL_LAST  = 16'(WALL_HALF - 1);
  localparam logic [15:0] BLOCK_LAST = 16'(BLOCK_HALF - 1);
  localparam logic [31:0] AMP_NEG    = ~AMP + 32'd1;

  state_e      state_q, state_d;
  logic [1:0]  req_q, req_d;
  logic        armed_q, armed_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  src_q, src_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic        phase_q, phase_d;

  logic [1:0]  req_in;
  logic [1:0]  req_edge;
  logic [1:0]  clr;
  logic        start;
  logic [15:0] half_last;

  assign req_in = {block_obstacle, wall_obstacle};

  // armed_q masks the first cycle after reset so a level held
  // through reset is captured without being seen as an edge.
  assign req_edge = req_in & ~req_q & {2{armed_q}};

  assign half_last = (src_q == TONE_WALL) ? WALL_LAST : BLOCK_LAST;

  always_comb begin
    state_d = state_q;
    req_d   = req_in;
    armed_d = 1'b1;
    src_d   = src_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    phase_d = phase_q;
    clr     = 2'b00;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        start = |pend_q;
      end
      BEEP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == BEEP_LAST) begin
          state_d = GAP;
          cnt_d   = 32'd0;
        end
        if (audio_out_allowed) begin
          if (scnt_q == half_last) begin
            scnt_d  = 16'd0;
            phase_d = ~phase_q;
          end else begin
            scnt_d = scnt_q + 16'd1;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = 32'd0;
          if (|pend_q) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d = BEEP;
      cnt_d   = 32'd0;
      scnt_d  = 16'd0;
      phase_d = 1'b1;
      if (pend_q[0]) begin
        src_d = TONE_WALL;
        clr   = 2'b01;
      end else begin
        src_d = TONE_BLOCK;
        clr   = 2'b10;
      end
    end

    // A fresh edge on the same cycle its beep starts stays pending.
    pend_d = (pend_q & ~clr) | req_edge;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 2'b00;
      armed_q <= 1'b0;
      pend_q  <= 2'b00;
      src_q   <= TONE_NONE;
      cnt_q   <= 32'd0;
      scnt_q  <= 16'd0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      phase_q <= phase_d;
    end
  end

  // Outputs are gated by reset so they read silent during reset.
  always_comb begin
    write_audio_out = audio_out_allowed;
    beep_active     = ~reset & (state_q == BEEP);
    tone_sel        = beep_active ? src_q : TONE_NONE;
    sample_out      = 32'd0;
    if (beep_active) begin
      sample_out = phase_q ? AMP : AMP_NEG;
    end
  end

endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed and random stimulus against a timeline
// model of the beep scheduler; a monitor scores every output beat.
module tb_beep_scheduler;

  localparam int BEEP = 100;
  localparam int GAP  = 20;
  localparam int WH   = 2;
  localparam int BH   = 4;
  localparam int AMP  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wall;
  logic        block;
  logic        allowed;
  logic        wr;
  logic [31:0] sample;
  logic        beep;
  logic [1:0]  tone;

  beep_scheduler #(
    .BEEP_CYCLES(BEEP),
    .GAP_CYCLES (GAP),
    .WALL_HALF  (WH),
    .BLOCK_HALF (BH),
    .AMP        (32'(AMP))
  ) dut (
    .CLOCK_50         (clk),
    .reset            (reset),
    .wall_obstacle    (wall),
    .block_obstacle   (block),
    .audio_out_allowed(allowed),
    .write_audio_out  (wr),
    .sample_out       (sample),
    .beep_active      (beep),
    .tone_sel         (tone)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] sample;
    logic        beep;
    logic [1:0]  tone;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   starts = 0;

  // Model: current segment (0 idle, 1 beep, 2 gap), cycles spent in it,
  // writes made during the beep, served source and pending requests.
  int m_mode = 0;
  int m_elapsed = 0;
  int m_writes = 0;
  int m_src = 0;
  bit m_pw = 0, m_pb = 0;
  bit m_prev_w = 0, m_prev_b = 0;
  bit m_armed = 0;

  function automatic exp_t m_expect(bit a, bit r);
    exp_t e;
    int   half;
    e = '0;
    e.wr = a;
    if (!r && m_mode == 1) begin
      half = (m_src == 1) ? WH : BH;
      e.beep = 1'b1;
      e.tone = 2'(m_src);
      if ((m_writes / half) % 2 == 0) e.sample = 32'(AMP);
      else e.sample = 32'(-AMP);
    end
    return e;
  endfunction

  function automatic bit m_start();
    if (m_pw) begin
      m_pw = 0;
      m_src = 1;
    end else if (m_pb) begin
      m_pb = 0;
      m_src = 2;
    end else begin
      return 0;
    end
    m_mode = 1;
    m_elapsed = 0;
    m_writes = 0;
    return 1;
  endfunction

  function automatic void m_step(bit w, bit b, bit a, bit r);
    bit ew, eb;
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_writes = 0; m_src = 0;
      m_pw = 0; m_pb = 0; m_prev_w = 0; m_prev_b = 0;
      m_armed = 0;
      return;
    end
    ew = m_armed && w && !m_prev_w;
    eb = m_armed && b && !m_prev_b;
    case (m_mode)
      0: void'(m_start());
      1: begin
        if (a) m_writes++;
        m_elapsed++;
        if (m_elapsed == BEEP) begin
          m_mode = 2;
          m_elapsed = 0;
        end
      end
      default: begin
        m_elapsed++;
        if (m_elapsed == GAP) begin
          if (!m_start()) m_mode = 0;
        end
      end
    endcase
    m_pw = m_pw | ew;
    m_pb = m_pb | eb;
    m_prev_w = w;
    m_prev_b = b;
    m_armed = 1;
  endfunction

  task automatic cyc(bit w, bit b, bit a, bit r);
    @(posedge clk);
    #2;
    wall = w; block = b; allowed = a; reset = r;
    #1;
    exp_q.push_back(m_expect(a, r));
    m_step(w, b, a, r);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 0);
  endtask

  task automatic chk_starts(string name, int want);
    n_cmp++;
    if (starts != want) begin
      n_bad++;
      $display("FAIL %s: beeps started=%0d, want %0d",
               name, starts, want);
    end
    starts = 0;
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_beep;
    prev_beep = 0;
    forever begin
      @(negedge clk);
      if (beep && !prev_beep) starts++;
      prev_beep = beep;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({wr, sample, beep, tone} !== e) begin
          n_bad++;
          $display("FAIL beat t=%0t: got wr=%b smp=%0d beep=%b tone=%b, want wr=%b smp=%0d beep=%b tone=%b",
                   $time, wr, $signed(sample), beep, tone,
                   e.wr, $signed(e.sample), e.beep, e.tone);
        end
      end
    end
  end

  initial begin : driver
    bit w, b;
    reset = 1; wall = 0; block = 0; allowed = 1;

    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    idle(3);
    starts = 0;

    // single wall pulse
    cyc(1, 0, 1, 0);
    idle(140);
    chk_starts("wall_pulse", 1);

    // wall and block rise together: wall, gap, block back-to-back
    cyc(1, 1, 1, 0);
    idle(260);
    chk_starts("both_rise", 2);

    // block held high: one beep only
    for (int i = 0; i < 500; i++) cyc(0, 1, 1, 0);
    idle(150);
    chk_starts("block_hold", 1);

    // three wall pulses during a wall beep collapse into one more
    cyc(1, 0, 1, 0);
    for (int p = 0; p < 3; p++) begin
      idle(19);
      cyc(1, 0, 1, 0);
    end
    idle(260);
    chk_starts("wall_collapse", 2);

    // write strobe toggling during the beep
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 140; i++) cyc(0, 0, i[0], 0);
    chk_starts("allowed_toggle", 1);

    // reset mid-beep with a block request pending
    cyc(1, 0, 1, 0);
    idle(3);
    cyc(0, 1, 1, 0);
    idle(45);
    cyc(0, 0, 1, 1);
    idle(200);
    chk_starts("reset_abort", 1);

    // random levels, write strobe and occasional reset
    w = 0; b = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) w = ~w;
      if ($urandom_range(0, 29) == 0) b = ~b;
      cyc(w, b, $urandom_range(0, 3) != 0,
          $urandom_range(0, 699) == 0);
    end
    idle(3);

    @(posedge clk);
    @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d beats unchecked, want 0",
               exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
